// File: rtl/i2c_pkg.sv
// Shared I2C state encodings and bus widths. Used by i2c_master_fsm and the SDA datapath.
package i2c_pkg;
  localparam int STATE_W = 3;
  localparam int CNT_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADDR  = 3'd2,
    ACK1  = 3'd3,
    DATA  = 3'd4,
    ACK2  = 3'd5,
    STOP  = 3'd6,
    RSVD  = 3'd7
  } i2c_state_e;

  // The unused code 7 behaves exactly like IDLE.
  function automatic i2c_state_e norm_state(input logic [STATE_W-1:0] s);
    return (s == RSVD) ? IDLE : i2c_state_e'(s);
  endfunction
endpackage

// File: rtl/i2c_sda_shifter.sv
// Holds the latched {addr,rw} and write byte, selects the current bit by cnt,
// and captures read data bit-by-bit.
module i2c_sda_shifter #(
  parameter int CNT_W  = 3,
  parameter int DATA_W = 8
) (
  input  logic              scl_clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [6:0]        addr_i,
  input  logic              rw_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [CNT_W-1:0]  cnt_i,
  input  logic              capture_i,
  input  logic              sda_in_i,
  output logic              addr_bit_o,
  output logic              data_bit_o,
  output logic              rw_o,
  output logic [DATA_W-1:0] rdata_o
);
  logic [7:0]        addr_sr_q, addr_sr_d;
  logic [DATA_W-1:0] data_sr_q, data_sr_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;

  always_comb begin
    addr_sr_d = addr_sr_q;
    data_sr_d = data_sr_q;
    rdata_d   = rdata_q;
    if (load_i) begin
      addr_sr_d = {addr_i, rw_i};
      data_sr_d = wdata_i;
    end
    // Repeated SCL-high samples within one bit simply overwrite: last one wins.
    if (capture_i) rdata_d[cnt_i] = sda_in_i;
  end

  always_ff @(posedge scl_clk or negedge reset) begin
    if (!reset) begin
      addr_sr_q <= '0;
      data_sr_q <= '0;
      rdata_q   <= '0;
    end else begin
      addr_sr_q <= addr_sr_d;
      data_sr_q <= data_sr_d;
      rdata_q   <= rdata_d;
    end
  end

  assign addr_bit_o = addr_sr_q[cnt_i];
  assign data_bit_o = data_sr_q[cnt_i];
  assign rw_o       = addr_sr_q[0];
  assign rdata_o    = rdata_q;
endmodule

// File: rtl/i2c_sda_datapath.sv
// SDA driver for a single-byte I2C transaction, slaved to i2c_master_fsm state/cnt/SCL.
// Optional I2C_NACK_COUNT_EN adds a saturating NACK event counter output.
module i2c_sda_datapath #(
  parameter int STATE_W = i2c_pkg::STATE_W,
  parameter int CNT_W   = i2c_pkg::CNT_W,
  parameter int DATA_W  = 2**CNT_W
) (
  input  logic               scl_clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] state,
  input  logic [CNT_W-1:0]   cnt,
  input  logic               SCL,
  input  logic               load,
  input  logic [6:0]         addr,
  input  logic               rw,
  input  logic [DATA_W-1:0]  wdata,
  input  logic               sda_in,
  output logic               sda_out,
  output logic               sda_oe,
  output logic [DATA_W-1:0]  rdata,
  output logic               ack_err,
  output logic               done,
  output logic               busy
`ifdef I2C_NACK_COUNT_EN
  , output logic [7:0]       nack_cnt
`endif
);
  import i2c_pkg::*;

  i2c_state_e st;
  i2c_state_e prev_state_q, prev_state_d;
  logic pending_q, pending_d;
  logic ack_err_q, ack_err_d;
  logic stop_seen_q, stop_seen_d;
  logic done_q, done_d;
  logic sda_out_q, sda_out_d;
  logic sda_oe_q, sda_oe_d;
  logic load_acc, capture, ack_sample;
  logic addr_bit, data_bit, rw_lat;

  assign st         = norm_state(state);
  assign load_acc   = load && (st == IDLE) && !pending_q;
  assign capture    = (st == DATA) && rw_lat && SCL;
  assign ack_sample = SCL && ((st == ACK1) || ((st == ACK2) && !rw_lat));

  i2c_sda_shifter #(.CNT_W(CNT_W), .DATA_W(DATA_W)) u_shifter (
    .scl_clk    (scl_clk),
    .reset      (reset),
    .load_i     (load_acc),
    .addr_i     (addr),
    .rw_i       (rw),
    .wdata_i    (wdata),
    .cnt_i      (cnt),
    .capture_i  (capture),
    .sda_in_i   (sda_in),
    .addr_bit_o (addr_bit),
    .data_bit_o (data_bit),
    .rw_o       (rw_lat),
    .rdata_o    (rdata)
  );

  always_comb begin
    pending_d = pending_q;
    if (load_acc)          pending_d = 1'b1;
    else if (st == START)  pending_d = 1'b0;

    ack_err_d = ack_err_q;
    if (load_acc)                 ack_err_d = 1'b0;
    else if (ack_sample && sda_in) ack_err_d = 1'b1;

    stop_seen_d  = (st == STOP) && (stop_seen_q || SCL);
    prev_state_d = st;
    done_d       = (prev_state_q == STOP) && (st != STOP);

    sda_oe_d  = 1'b0;
    sda_out_d = 1'b1;
    case (st)
      START: begin sda_oe_d = 1'b1; sda_out_d = 1'b0; end
      ADDR:  begin sda_oe_d = 1'b1; sda_out_d = addr_bit; end
      DATA:  if (!rw_lat) begin sda_oe_d = 1'b1; sda_out_d = data_bit; end
      ACK2:  if (rw_lat) sda_oe_d = 1'b1;
      // Hold SDA low until SCL has been seen high, then release-high for the STOP edge.
      STOP:  begin sda_oe_d = 1'b1; sda_out_d = stop_seen_d; end
      default: ;
    endcase
  end

  always_ff @(posedge scl_clk or negedge reset) begin
    if (!reset) begin
      prev_state_q <= IDLE;
      pending_q    <= 1'b0;
      ack_err_q    <= 1'b0;
      stop_seen_q  <= 1'b0;
      done_q       <= 1'b0;
      sda_out_q    <= 1'b1;
      sda_oe_q     <= 1'b0;
    end else begin
      prev_state_q <= prev_state_d;
      pending_q    <= pending_d;
      ack_err_q    <= ack_err_d;
      stop_seen_q  <= stop_seen_d;
      done_q       <= done_d;
      sda_out_q    <= sda_out_d;
      sda_oe_q     <= sda_oe_d;
    end
  end

  assign sda_out = sda_out_q;
  assign sda_oe  = sda_oe_q;
  assign ack_err = ack_err_q;
  assign done    = done_q;
  // Gated by reset so busy drops at once even if the FSM state input lags.
  assign busy    = reset && (pending_q || (st != IDLE));

`ifdef I2C_NACK_COUNT_EN
  logic [7:0] nack_cnt_q, nack_cnt_d;

  always_comb begin
    nack_cnt_d = nack_cnt_q;
    if (ack_err_d && !ack_err_q && (nack_cnt_q != 8'hFF)) nack_cnt_d = nack_cnt_q + 8'd1;
  end

  always_ff @(posedge scl_clk or negedge reset) begin
    if (!reset) nack_cnt_q <= '0;
    else        nack_cnt_q <= nack_cnt_d;
  end

  assign nack_cnt = nack_cnt_q;
`endif
endmodule
